fourteen_serializer: RTL and testbench
======================================

Name: fourteen_serializer

Overview:
- Downstream consumer of the 4-bit clearable, tri-statable holding register. It samples the register's Q bus when that bus is actively driven.
- It transmits the captured word as a framed serial bit stream: start bit, WIDTH data bits LSB first, even parity bit, stop bit.
- It gives the lab datapath a serial output stage with busy/done status.
- It rejects load requests while the bus is high-Z or while a frame is in progress.

Parameters:
- WIDTH, 4, data word width; matches the register width.
- DIV, 4, clock cycles per serial bit (>=1).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  asynchronous, active-high reset; same polarity as the register's clear.
- D  input  WIDTH  parallel data; connects to the register's Q bus.
- OE  input  1  mirror of the register's OE; 1 = bus high-Z (data invalid), 0 = bus driven.
- LOAD  input  1  request to capture D and start a frame; level-sampled each clock.
- SO  output  1  serial out; idles high.
- BUSY  output  1  high while a frame is in progress.
- DONE  output  1  one-cycle pulse when the stop bit completes.
- REJ  output  1  one-cycle pulse when a LOAD is refused.

Behaviour:
- Reset (CLR=1, asynchronous, overrides all inputs):
  - State=IDLE, SO=1, BUSY=0, DONE=0, REJ=0.
  - Shift register, bit counter and divider counter all 0.
  - CLR mid-frame aborts the frame immediately; no DONE is produced.
- States: IDLE, START, DATA, PARITY, STOP. Registered outputs: SO, BUSY, DONE, REJ.
- IDLE:
  - SO=1, BUSY=0.
  - On an edge with LOAD=1 and OE=0: capture D into the shift register, compute parity = XOR of D, go to START. SO=0 and BUSY=1 are visible after that edge; capture-to-start-bit latency is 1 cycle.
- LOAD=1 with OE=1 in IDLE: no capture, stay in IDLE, REJ=1 for one cycle.
- START: SO=0 for DIV cycles, then go to DATA with bit counter=0.
- DATA:
  - SO = shift register bit 0 for DIV cycles, then shift right.
  - Increment the bit counter. After WIDTH bits, go to PARITY.
- PARITY: SO = parity bit, so the total count of 1s over data+parity is even. Lasts DIV cycles, then go to STOP.
- STOP:
  - SO=1 for DIV cycles.
  - On the final cycle's edge: go to IDLE, BUSY=0, DONE=1 for exactly one cycle.
- Frame length is exactly (WIDTH+3)*DIV clocks from the first SO=0 to BUSY falling.
- Divider: counts 0..DIV-1 within each bit and wraps to 0 on each bit change. With DIV=1, every bit lasts one clock.
- LOAD while BUSY=1 (any value of OE): ignored, REJ=1 pulse, frame unaffected. Holding LOAD high during a frame gives REJ every cycle.
- LOAD on the same edge that returns STOP to IDLE: refused (REJ=1). A new frame may start on the first IDLE edge after that.
- D and OE are ignored outside the capture edge. Changes to D mid-frame do not affect SO.
- The bench must never assert LOAD with OE=0 while D is undriven.

Test Plan:
- CLR=1 for 100 ns, then release -> SO=1, BUSY=0, DONE=0, REJ=0; assert CLR mid-frame -> SO=1 and BUSY=0 asynchronously, no DONE.
- DIV=4: D=4'b0101, OE=0, 1-cycle LOAD -> SO bit sequence 0,1,0,1,0,0,1, each 4 clocks; BUSY high 28 clocks; DONE pulses once.
- D=4'b0111 -> data bits 1,1,1,0, parity 1; D=4'b0000 -> parity 0. Check SO at each bit midpoint.
- OE=1, D=4'b1010, LOAD=1 for one cycle -> REJ pulse, BUSY stays 0, SO stays 1.
- LOAD held high through a whole frame of 4'b1100 -> first edge starts the frame; REJ asserted every subsequent busy cycle; the frame bits are unchanged.
- DIV=1 with back-to-back LOADs -> 7-clock frames; LOAD on the STOP-exit edge is rejected and the following LOAD is accepted.

Source files
------------

// File: rtl/fourteen_serializer.sv
// rtl/fourteen_serializer.sv - framed serial transmitter for the 4-bit holding register bus
// Frame: start(0), WIDTH data bits LSB first, even parity, stop(1); each bit lasts DIV clocks.
module fourteen_serializer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             OE,
  input  logic             LOAD,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE,
  output logic             REJ
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             par, par_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [DW-1:0]    div_cnt, div_cnt_n;
  logic             so_n, busy_n, done_n, rej_n;
  logic             bit_end;

  assign bit_end = (div_cnt == DW'(DIV - 1));

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    par_n     = par;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    so_n      = SO;
    busy_n    = BUSY;
    done_n    = 1'b0;
    rej_n     = 1'b0;
    if (state == IDLE) begin
      so_n   = 1'b1;
      busy_n = 1'b0;
      if (LOAD) begin
        if (!OE) begin
          shreg_n   = D;
          par_n     = ^D;
          bit_cnt_n = '0;
          div_cnt_n = '0;
          state_n   = START;
          so_n      = 1'b0;
          busy_n    = 1'b1;
        end else begin
          rej_n = 1'b1;
        end
      end
    end else begin
      // Any request during a frame, including the STOP-exit edge, is refused.
      rej_n     = LOAD;
      div_cnt_n = bit_end ? '0 : div_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          START: begin
            state_n   = DATA;
            bit_cnt_n = '0;
            so_n      = shreg[0];
          end
          DATA: begin
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              state_n = PARITY;
              so_n    = par;
            end else begin
              so_n = shreg_n[0];
            end
          end
          PARITY: begin
            state_n = STOP;
            so_n    = 1'b1;
          end
          STOP: begin
            state_n = IDLE;
            so_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
          default: begin
            state_n = IDLE;
            so_n    = 1'b1;
            busy_n  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      shreg   <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      SO      <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      REJ     <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      par     <= par_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
      SO      <= so_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
      REJ     <= rej_n;
    end
  end

endmodule

// File: tb/tb_fourteen_serializer.sv
// tb/tb_fourteen_serializer.sv - directed self-checking bench for fourteen_serializer
// Two instances: DIV=4 (u4) and DIV=1 (u1) share clock, clear, data and OE.
module tb_fourteen_serializer;

  logic       CLK;
  logic       CLR;
  logic [3:0] D;
  logic       OE;
  logic       load4, load1;
  logic       so4, busy4, done4, rej4;
  logic       so1, busy1, done1, rej1;
  logic       sel;
  int         total;
  int         bad;

  fourteen_serializer #(.WIDTH(4), .DIV(4)) u4 (
    .CLK(CLK), .CLR(CLR), .D(D), .OE(OE), .LOAD(load4),
    .SO(so4), .BUSY(busy4), .DONE(done4), .REJ(rej4)
  );

  fourteen_serializer #(.WIDTH(4), .DIV(1)) u1 (
    .CLK(CLK), .CLR(CLR), .D(D), .OE(OE), .LOAD(load1),
    .SO(so1), .BUSY(busy1), .DONE(done1), .REJ(rej1)
  );

  wire so_s   = sel ? so1   : so4;
  wire busy_s = sel ? busy1 : busy4;
  wire done_s = sel ? done1 : done4;
  wire rej_s  = sel ? rej1  : rej4;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_load(input logic v);
    if (sel) load1 = v;
    else     load4 = v;
  endtask

  // Entered just after the capture edge; bits[0] is the start bit, bits[6] the stop bit.
  task automatic run_frame(input logic [6:0] bits, input int div, input bit hold, input bit exit_load);
    for (int i = 0; i < 7 * div; i++) begin
      chk("so_bit", so_s, bits[i / div]);
      chk("busy_in_frame", busy_s, 1'b1);
      chk("done_in_frame", done_s, 1'b0);
      chk("rej_in_frame", rej_s, (hold && i > 0) ? 1'b1 : 1'b0);
      if (i == 0) begin
        D = ~D;
        if (!hold) set_load(1'b0);
      end
      if (exit_load && i == 7 * div - 1) set_load(1'b1);
      tick();
    end
    chk("busy_end", busy_s, 1'b0);
    chk("done_end", done_s, 1'b1);
    chk("so_end", so_s, 1'b1);
    chk("rej_end", rej_s, (hold || exit_load) ? 1'b1 : 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 1'b0;
    CLR   = 1'b1;
    D     = 4'b0000;
    OE    = 1'b1;
    load4 = 1'b0;
    load1 = 1'b0;

    #100;
    chk("rst_so", so4, 1'b1);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_rej", rej4, 1'b0);
    CLR = 1'b0;
    tick();
    chk("idle_so", so4, 1'b1);
    chk("idle_busy", busy4, 1'b0);
    chk("idle_so1", so1, 1'b1);

    // 0101: 0,1,0,1,0,0,1 with D flipped mid-frame
    D = 4'b0101; OE = 1'b0; load4 = 1'b1;
    tick();
    run_frame(7'b1001010, 4, 1'b0, 1'b0);
    tick();
    chk("done_one_cycle", done4, 1'b0);

    // 0111: data 1,1,1,0 parity 1
    D = 4'b0111; load4 = 1'b1;
    tick();
    run_frame(7'b1101110, 4, 1'b0, 1'b0);
    tick();

    // 0000: parity 0
    D = 4'b0000; load4 = 1'b1;
    tick();
    run_frame(7'b1000000, 4, 1'b0, 1'b0);
    tick();

    // Bus high-Z: refused
    OE = 1'b1; D = 4'b1010; load4 = 1'b1;
    tick();
    chk("hiz_rej", rej4, 1'b1);
    chk("hiz_busy", busy4, 1'b0);
    chk("hiz_so", so4, 1'b1);
    load4 = 1'b0;
    tick();
    chk("hiz_rej_clear", rej4, 1'b0);
    chk("hiz_busy2", busy4, 1'b0);

    // LOAD held through a frame of 1100: 0,0,0,1,1,0,1
    OE = 1'b0; D = 4'b1100; load4 = 1'b1;
    tick();
    run_frame(7'b1011000, 4, 1'b1, 1'b0);
    load4 = 1'b0;
    tick();
    chk("hold_after_rej", rej4, 1'b0);
    chk("hold_after_busy", busy4, 1'b0);
    chk("hold_after_done", done4, 1'b0);

    // DIV=1 back-to-back; LOAD on STOP exit refused, next LOAD accepted
    sel = 1'b1;
    D = 4'b0101; load1 = 1'b1;
    tick();
    run_frame(7'b1001010, 1, 1'b0, 1'b1);
    D = 4'b0111;
    tick();
    chk("b2b_accept_busy", busy1, 1'b1);
    chk("b2b_accept_so", so1, 1'b0);
    chk("b2b_accept_rej", rej1, 1'b0);
    chk("b2b_accept_done", done1, 1'b0);
    run_frame(7'b1101110, 1, 1'b0, 1'b0);
    tick();
    chk("b2b_done_clear", done1, 1'b0);
    sel = 1'b0;

    // Asynchronous clear mid-frame
    D = 4'b1111; load4 = 1'b1;
    tick();
    load4 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_clr_busy", busy4, 1'b1);
    CLR = 1'b1;
    #1;
    chk("clr_async_so", so4, 1'b1);
    chk("clr_async_busy", busy4, 1'b0);
    #20;
    CLR = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_clr_done", done4, 1'b0);
      chk("post_clr_so", so4, 1'b1);
    end
    chk("post_clr_busy", busy4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
